// File: rtl/stg1fq_pkg.sv
// Shared sizes and helpers for the instruction fetch queue.
// Guarded defaults for the shared size macros; a project-wide header may predefine them.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR (`SIZE_ADDR - 1)
`endif
`ifndef HBIT_DATA
`define HBIT_DATA (`SIZE_DATA - 1)
`endif
`ifndef SIZE_FQ_DEPTH
`define SIZE_FQ_DEPTH 4
`endif

package stg1fq_pkg;

    localparam int FQ_DEPTH  = `SIZE_FQ_DEPTH;
    localparam int FQ_ADDR_W = `SIZE_ADDR;
    localparam int FQ_DATA_W = `SIZE_DATA;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A simultaneous push and pop leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic push, input logic pop);
        if (push && !pop) return CNT_INC;
        if (pop && !push) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/stg1fq.sv
// Instruction fetch queue: first-word-fall-through circular buffer of {pc, instr}
// between fetch and decode, with a single-cycle flush for redirects.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_FQ_DEPTH
`define SIZE_FQ_DEPTH 4
`endif

module stg1fq
    import stg1fq_pkg::*;
#(
    parameter int DEPTH  = `SIZE_FQ_DEPTH,
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int DATA_W = `SIZE_DATA
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_flush,
    input  logic                     iw_valid,
    input  logic [ADDR_W-1:0]        iw_pc,
    input  logic [DATA_W-1:0]        iw_instr,
    output logic                     ow_ready,
    output logic                     ow_valid,
    output logic [ADDR_W-1:0]        ow_pc,
    output logic [DATA_W-1:0]        ow_instr,
    input  logic                     iw_ready,
    output logic [$clog2(DEPTH):0]   ow_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Ready and valid come from registered occupancy only, so a full queue refuses
    // a push even while decode is popping.
    assign ow_ready = (count != CNT_FULL);
    assign ow_valid = (count != '0);
    assign ow_count = count;

    assign push = iw_valid && ow_ready && !iw_flush;
    assign pop  = ow_valid && iw_ready && !iw_flush;

    assign head     = mem[rd_ptr];
    assign ow_pc    = head[ENTRY_W-1:DATA_W];
    assign ow_instr = head[DATA_W-1:0];

    always_comb begin
        count_nxt = count;
        case (cnt_op(push, pop))
            CNT_INC: count_nxt = count + CNT_ONE;
            CNT_DEC: count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (iw_flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {iw_pc, iw_instr};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_stg1fq.sv
// Self-checking bench for stg1fq: scoreboard queue of pushed entries, compared on every pop.
module tb_stg1fq;
    import stg1fq_pkg::*;

    localparam int DEPTH   = FQ_DEPTH;
    localparam int AW      = FQ_ADDR_W;
    localparam int DW      = FQ_DATA_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [AW-1:0]     in_pc;
    logic [DW-1:0]     in_instr;
    logic              out_ready;
    logic              out_valid;
    logic [AW-1:0]     out_pc;
    logic [DW-1:0]     out_instr;
    logic              dec_ready;
    logic [CNT_W-1:0]  out_count;

    logic [AW+DW-1:0]  sb [$];
    int                total;
    int                passed;
    int                pops_seen;

    stg1fq dut (
        .iw_clk   (clk),
        .iw_rst   (rst),
        .iw_flush (flush),
        .iw_valid (in_valid),
        .iw_pc    (in_pc),
        .iw_instr (in_instr),
        .ow_ready (out_ready),
        .ow_valid (out_valid),
        .ow_pc    (out_pc),
        .ow_instr (out_instr),
        .iw_ready (dec_ready),
        .ow_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: set inputs on the falling edge, check the pre-edge state
    // against the model, update the scoreboard, then wait for the rising edge.
    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                         input logic rdy, input logic fl, input logic rs);
        logic [AW+DW-1:0] exp_e;
        logic             full_m;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        dec_ready = rdy;
        flush     = fl;
        rst       = rs;
        #1;
        full_m = (sb.size() == DEPTH);
        total++;
        if (out_count !== CNT_W'(sb.size()))
            $display("FAIL count: got %0d want %0d", out_count, sb.size());
        else passed++;
        total++;
        if (out_valid !== (sb.size() != 0) || out_ready !== !full_m)
            $display("FAIL flags: valid=%b ready=%b want valid=%b ready=%b",
                     out_valid, out_ready, sb.size() != 0, !full_m);
        else passed++;
        if (sb.size() != 0 && rdy && !fl && !rs) begin
            exp_e = sb.pop_front();
            pops_seen++;
            total++;
            if ({out_pc, out_instr} !== exp_e)
                $display("FAIL pop_data: pc=%h instr=%h want pc=%h instr=%h",
                         out_pc, out_instr, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
            else passed++;
        end
        if (rs || fl) sb.delete();
        else if (v && !full_m) sb.push_back({pc, ins});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; dec_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        total++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_count !== '0)
            $display("FAIL reset_flags: valid=%b ready=%b count=%0d want 0 1 0",
                     out_valid, out_ready, out_count);
        else passed++;
        total++;
        if (out_pc !== '0 || out_instr !== '0)
            $display("FAIL reset_data: pc=%h instr=%h want 0 0", out_pc, out_instr);
        else passed++;
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_single_push();
        drive(1'b1, AW'('h10), DW'('hA5), 1'b0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== AW'('h10) || out_instr !== DW'('hA5) || out_count !== CNT_W'(1))
            $display("FAIL single_push: valid=%b pc=%h instr=%h count=%0d want 1 10 a5 1",
                     out_valid, out_pc, out_instr, out_count);
        else passed++;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++)
            drive(1'b1, AW'(i), DW'(32'hC000 + i), 1'b0, 1'b0, 1'b0);
        total++;
        if (out_ready !== 1'b0 || out_count !== CNT_W'(4))
            $display("FAIL full: ready=%b count=%0d want 0 4", out_ready, out_count);
        else passed++;
        drive(1'b1, AW'(5), DW'(32'hC005), 1'b1, 1'b0, 1'b0);
        total++;
        if (out_count !== CNT_W'(3) || out_ready !== 1'b1)
            $display("FAIL full_pop: count=%0d ready=%b want 3 1", out_count, out_ready);
        else passed++;
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        // Empty boundary: decode ready on an empty queue must not underflow.
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b0 || out_count !== '0)
            $display("FAIL empty_hold: valid=%b count=%0d want 0 0", out_valid, out_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = pops_seen;
        for (int i = 1; i <= 10; i++)
            drive(1'b1, AW'(i), DW'(32'hB000 + i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (pops_seen - start_pops !== 10 || out_valid !== 1'b0)
            $display("FAIL stream: pops=%0d valid=%b want 10 0", pops_seen - start_pops, out_valid);
        else passed++;
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++)
            drive(1'b1, AW'(32'h20 + i), DW'(32'hF000 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'('h99), DW'('h99), 1'b1, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0 || out_count !== '0 || out_ready !== 1'b1)
            $display("FAIL flush: valid=%b count=%0d ready=%b want 0 0 1",
                     out_valid, out_count, out_ready);
        else passed++;
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, AW'('h30), DW'('h31), 1'b0, 1'b0, 1'b0);
        total++;
        if (out_pc !== AW'('h30) || out_instr !== DW'('h31))
            $display("FAIL post_flush: pc=%h instr=%h want 30 31", out_pc, out_instr);
        else passed++;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        drive(1'b1, AW'('h41), DW'('h51), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'('h42), DW'('h52), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'('h43), DW'('h53), 1'b1, 1'b1, 1'b1);
        rst = 1'b0; flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_count !== '0 || out_pc !== '0 || out_instr !== '0)
            $display("FAIL mid_reset: valid=%b count=%0d pc=%h instr=%h want 0 0 0 0",
                     out_valid, out_count, out_pc, out_instr);
        else passed++;
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        pops_seen = 0;
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stg1fq.md
# stg1fq

Instruction fetch queue between the fetch stage (producer of `{pc, instr}` pairs) and the decode stage (consumer). It is a small first-word-fall-through FIFO with valid/ready handshakes on both sides and a single-cycle flush. It decouples fetch from decode so that decode back-pressure never drops a fetched instruction, and it discards wrong-path instructions on a redirect.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, minimum 2.
- `ADDR_W`, default `` `SIZE_ADDR ``: PC width.
- `DATA_W`, default `` `SIZE_DATA ``: instruction width.

Ports:
- `iw_clk`, input, 1: clock. One clock domain.
- `iw_rst`, input, 1: reset. Synchronous, active-high.
- `iw_flush`, input, 1: discard all entries, including any push in the same cycle.
- `iw_valid`, input, 1: the fetch side presents an entry.
- `iw_pc`, input, ADDR_W: PC of the entry being pushed.
- `iw_instr`, input, DATA_W: instruction word being pushed.
- `ow_ready`, output, 1: the queue can accept a push this cycle.
- `ow_valid`, output, 1: the head entry is valid.
- `ow_pc`, output, ADDR_W: PC of the head entry.
- `ow_instr`, output, DATA_W: instruction of the head entry.
- `iw_ready`, input, 1: decode consumes the head entry this cycle.
- `ow_count`, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer.
  - `wr_ptr` and `rd_ptr` are clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is clog2(DEPTH)+1 bits wide.
- Push fires when `iw_valid && ow_ready && !iw_flush`.
  - Writes `{iw_pc, iw_instr}` at `wr_ptr`, then increments `wr_ptr`.
- Pop fires when `ow_valid && iw_ready && !iw_flush`.
  - Increments `rd_ptr`.
- Count update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop fire together, or when neither fires.
- `ow_ready` = (`count` != DEPTH).
  - Depends only on registered state; it never depends on `iw_ready`.
  - A push into a full queue is refused even when a pop happens in the same cycle.
- `ow_valid` = (`count` != 0).
- `ow_pc` / `ow_instr` are read combinationally from the entry at `rd_ptr`.
  - When `ow_valid` is 0, they show stale storage contents.
- Flush:
  - Sets `wr_ptr`, `rd_ptr` and `count` to 0 on the next edge.
  - Storage contents are not cleared.
  - A push and pop in the flush cycle are both ignored.
- Reset:
  - `wr_ptr`, `rd_ptr` and `count` go to 0, and all storage entries go to 0.
  - After reset: `ow_valid` = 0, `ow_ready` = 1, `ow_pc` = 0, `ow_instr` = 0, `ow_count` = 0.
  - Reset takes priority over flush and over any handshake.
- If `iw_valid` is high while `ow_ready` is low, the producer must hold `iw_pc` / `iw_instr` stable. The queue does not check this.

## Timing
- Push to visible: an entry pushed at edge N raises `ow_valid` after edge N. There is no same-cycle bypass, so the empty-queue latency is 1 cycle.
- Full throughput: at steady state with occupancy between 1 and DEPTH−1, one push and one pop per cycle are sustained.
- Full boundary: at `count` = DEPTH, `ow_ready` = 0. It returns to 1 in the cycle after the first pop.
- Empty boundary: at `count` = 0, `iw_ready` is ignored. `rd_ptr` and `count` do not underflow.
- Wrap: pointers roll from DEPTH−1 to 0 with no bubble.
- Flush: takes effect at the next edge. After that edge, `ow_valid` = 0 and `ow_ready` = 1.
- Reset mid-operation: on the next edge, all state returns to the reset values. Entries that were in flight are lost.

## Structure
- Widths come from the shared `sizes.vh` (`SIZE_ADDR`, `SIZE_DATA`, `HBIT_*`).
- Add `SIZE_FQ_DEPTH` (default 4) to the same shared header, so the top level and the benches agree on depth.
- Single module with no sub-modules. Pointer and count logic is inline.
- Storage is one register array of width ADDR_W+DATA_W, holding the concatenated `{pc, instr}`.

## Test plan
- Reset, then hold idle → `ow_valid`=0, `ow_ready`=1, `ow_count`=0, `ow_pc`=0, `ow_instr`=0.
- Push pc=0x10, instr=0xA5 into an empty queue with `iw_ready`=0 → the next cycle shows `ow_valid`=1, `ow_pc`=0x10, `ow_instr`=0xA5, `ow_count`=1.
- Push 4 entries (pc 1..4) with `iw_ready`=0:
  - Expect `ow_ready`=0 and `ow_count`=4.
  - A 5th `iw_valid` with `iw_ready`=1 in the same cycle → only the pop fires, `ow_count`=3, and entry 5 is not stored.
- Stream 10 entries with `iw_valid`=`iw_ready`=1 constantly → decode receives pc 1..10 in order, one per cycle after the first-cycle latency, with pointers wrapping twice.
- With 3 entries queued, assert `iw_flush` together with `iw_valid` (pc=0x99) → next cycle `ow_valid`=0, `ow_count`=0, and 0x99 is never output.
- With 2 entries queued, assert `iw_rst` for one cycle → next cycle `ow_valid`=0, `ow_count`=0, `ow_pc`=0.
